// File: rtl/synth_pkg.sv
// Shared constants and state encoding for the pitch scan sequencer and its datapath.
package synth_pkg;

    localparam int unsigned V_WIDTH        = 3;
    localparam int unsigned O_WIDTH        = 2;
    localparam int unsigned OE_WIDTH       = 1;
    localparam int unsigned PITCH_WIDTH    = 24;
    localparam int unsigned PITCH_PIPE_LAT = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/pitch_scan_ctrl_if.sv
// Request, datapath-index and pitch-table-write signals of the pitch scan controller.
interface pitch_scan_ctrl_if #(
    parameter int unsigned V_WIDTH  = synth_pkg::V_WIDTH,
    parameter int unsigned O_WIDTH  = synth_pkg::O_WIDTH,
    parameter int unsigned OE_WIDTH = synth_pkg::OE_WIDTH
);
    localparam int unsigned E_WIDTH = O_WIDTH + OE_WIDTH;
    localparam int unsigned P_WIDTH = synth_pkg::PITCH_WIDTH;

    logic                       voice_req;
    logic [V_WIDTH-1:0]         voice_num;
    logic                       all_req;
    logic [V_WIDTH+E_WIDTH-1:0] xxxx;
    logic [P_WIDTH-1:0]         pitch_in;
    logic                       wr_en;
    logic [V_WIDTH+O_WIDTH-1:0] wr_adr;
    logic [P_WIDTH-1:0]         wr_data;
    logic                       busy;
    logic                       voice_done;
    logic [V_WIDTH-1:0]         voice_done_num;

    modport master (
        output voice_req, voice_num, all_req, pitch_in,
        input  xxxx, wr_en, wr_adr, wr_data, busy, voice_done, voice_done_num
    );

    modport slave (
        input  voice_req, voice_num, all_req, pitch_in,
        output xxxx, wr_en, wr_adr, wr_data, busy, voice_done, voice_done_num
    );

endinterface

// File: rtl/pitch_scan_ctrl_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index strictly after last, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic         valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned idx;
            idx = 32'(last) + k;
            if (idx >= N) idx = idx - N;
            if (!valid && req[W'(idx)]) begin
                grant = W'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pitch_scan_ctrl.sv
// Walks the datapath index through every pending voice, holding each slot SETTLE
// cycles, and writes the settled oscillator pitch into the pitch table.
module pitch_scan_ctrl #(
    parameter int unsigned VOICES   = 8,
    parameter int unsigned V_OSC    = 4,
    parameter int unsigned V_WIDTH  = synth_pkg::V_WIDTH,
    parameter int unsigned O_WIDTH  = synth_pkg::O_WIDTH,
    parameter int unsigned OE_WIDTH = synth_pkg::OE_WIDTH,
    parameter int unsigned E_WIDTH  = O_WIDTH + OE_WIDTH,
    parameter int unsigned SETTLE   = synth_pkg::PITCH_PIPE_LAT + 1
) (
    input  logic             const_clk,
    input  logic             iRST,
    pitch_scan_ctrl_if.slave bus
);
    import synth_pkg::scan_state_t;
    import synth_pkg::ST_IDLE;
    import synth_pkg::ST_SCAN;

    localparam int unsigned X_WIDTH   = V_WIDTH + E_WIDTH;
    localparam int unsigned CNT_WIDTH = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    scan_state_t          state;
    logic [VOICES-1:0]    pending;
    logic [VOICES-1:0]    set_mask;
    logic [VOICES-1:0]    clr_mask;
    logic [V_WIDTH-1:0]   v;
    logic [V_WIDTH-1:0]   last_voice;
    logic [V_WIDTH-1:0]   arb_last;
    logic [V_WIDTH-1:0]   grant;
    logic                 grant_valid;
    logic [O_WIDTH-1:0]   ox;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 slot_end;
    logic                 voice_end;
    logic                 take;

    // While scanning, the voice in progress is the round-robin reference point.
    assign arb_last = (state == ST_SCAN) ? v : last_voice;

    rr_arbiter #(
        .N (VOICES),
        .W (V_WIDTH)
    ) u_arb (
        .req   (pending),
        .last  (arb_last),
        .grant (grant),
        .valid (grant_valid)
    );

    assign slot_end  = (state == ST_SCAN) && (cnt == CNT_WIDTH'(SETTLE - 1));
    assign voice_end = slot_end && (ox == O_WIDTH'(V_OSC - 1));
    assign take      = grant_valid && ((state == ST_IDLE) || voice_end);

    assign bus.xxxx = X_WIDTH'({v, ox, {OE_WIDTH{1'b0}}});

    // Request set mask and grant clear mask; set is OR-ed last so it wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (bus.voice_req) set_mask[bus.voice_num] = 1'b1;
        if (bus.all_req)   set_mask = '1;
        if (take)          clr_mask[grant] = 1'b1;
    end

    always_ff @(posedge const_clk) begin
        if (iRST) begin
            state              <= ST_IDLE;
            pending            <= '1;
            last_voice         <= V_WIDTH'(VOICES - 1);
            v                  <= '0;
            ox                 <= '0;
            cnt                <= '0;
            bus.wr_en          <= 1'b0;
            bus.wr_adr         <= '0;
            bus.wr_data        <= '0;
            bus.busy           <= 1'b0;
            bus.voice_done     <= 1'b0;
            bus.voice_done_num <= '0;
        end else begin
            pending        <= (pending & ~clr_mask) | set_mask;
            bus.wr_en      <= slot_end;
            bus.voice_done <= voice_end;
            if (slot_end) begin
                bus.wr_adr  <= {v, ox};
                bus.wr_data <= bus.pitch_in;
            end
            if (voice_end) begin
                bus.voice_done_num <= v;
                last_voice         <= v;
            end
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state    <= ST_SCAN;
                        bus.busy <= 1'b1;
                        v        <= grant;
                        ox       <= '0;
                        cnt      <= '0;
                    end
                end
                ST_SCAN: begin
                    if (!slot_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!voice_end) begin
                            ox <= ox + 1'b1;
                        end else if (grant_valid) begin
                            v  <= grant;
                            ox <= '0;
                        end else begin
                            state    <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pitch_scan_ctrl.sv
// Randomised and directed bench for pitch_scan_ctrl against a slot-level reference model.
module tb_pitch_scan_ctrl;

    localparam int unsigned VOICES   = 8;
    localparam int unsigned V_OSC    = 4;
    localparam int unsigned SETTLE   = 4;
    localparam int unsigned VW       = 3;
    localparam int unsigned OW       = 2;
    localparam int unsigned OEW      = 1;
    localparam int          SCAN_LEN = V_OSC * SETTLE;

    logic clk = 1'b0;
    logic rst;

    pitch_scan_ctrl_if #(.V_WIDTH(VW), .O_WIDTH(OW), .OE_WIDTH(OEW)) bus ();

    pitch_scan_ctrl #(
        .VOICES(VOICES), .V_OSC(V_OSC), .V_WIDTH(VW), .O_WIDTH(OW),
        .OE_WIDTH(OEW), .E_WIDTH(OW + OEW), .SETTLE(SETTLE)
    ) dut (
        .const_clk (clk),
        .iRST      (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: pending set, round-robin pointer, and the voice being scanned
    // described by its start cycle (slot = elapsed / SETTLE).
    bit [VOICES-1:0] pend;
    int              last_v;
    int              cur_v;
    int              start;
    bit              scanning;
    bit              armed = 1'b0;
    bit              post_rst;
    bit              e_wr;
    bit              e_done;
    int              e_adr;
    int              e_num;
    logic [23:0]     e_data;

    int obs_wr, obs_done, obs_done3, first_wr, done_at;
    int done_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit vr, input int vn, input bit ar);
        int          k;
        int          g;
        int          idx;
        bit          decide;
        logic [23:0] pitch;
        @(negedge clk);
        if (armed) begin
            check("busy", 32'(bus.busy), 32'(scanning));
            check("wr_en", 32'(bus.wr_en), 32'(e_wr));
            check("voice_done", 32'(bus.voice_done), 32'(e_wr & e_done));
            if (e_wr) begin
                check("wr_adr", 32'(bus.wr_adr), 32'(e_adr));
                check("wr_data", 32'(bus.wr_data), 32'(e_data));
                if (e_done) check("voice_done_num", 32'(bus.voice_done_num), 32'(e_num));
            end
            if (scanning) begin
                k = cyc - start;
                check("xxxx", 32'(bus.xxxx), 32'((cur_v * V_OSC + k / SETTLE) << OEW));
            end
            if (post_rst) begin
                check("rst_xxxx", 32'(bus.xxxx), 32'(0));
                check("rst_wr_adr", 32'(bus.wr_adr), 32'(0));
                check("rst_wr_data", 32'(bus.wr_data), 32'(0));
                check("rst_done_num", 32'(bus.voice_done_num), 32'(0));
            end
        end
        if (bus.wr_en === 1'b1) begin
            obs_wr++;
            if (first_wr < 0) first_wr = cyc;
        end
        if (bus.voice_done === 1'b1) begin
            obs_done++;
            if (bus.voice_done_num === 3'd3) obs_done3++;
            done_at = cyc;
            done_q.push_back(int'(bus.voice_done_num));
        end

        pitch         = 24'(cyc * 5 + int'($urandom_range(0, 3)));
        rst           = r;
        bus.voice_req = vr;
        bus.voice_num = VW'(vn);
        bus.all_req   = ar;
        bus.pitch_in  = pitch;

        e_wr     = 1'b0;
        e_done   = 1'b0;
        post_rst = 1'b0;
        if (r) begin
            pend     = '1;
            last_v   = VOICES - 1;
            scanning = 1'b0;
            armed    = 1'b1;
            post_rst = 1'b1;
        end else if (armed) begin
            k      = cyc - start;
            decide = !scanning;
            if (scanning) begin
                if (k % SETTLE == SETTLE - 1) begin
                    e_wr   = 1'b1;
                    e_adr  = cur_v * V_OSC + k / SETTLE;
                    e_data = pitch;
                    e_done = (k == SCAN_LEN - 1);
                    e_num  = cur_v;
                end
                if (k == SCAN_LEN - 1) begin
                    decide = 1'b1;
                    last_v = cur_v;
                end
            end
            if (decide) begin
                g = -1;
                for (int j = 1; j <= VOICES; j++) begin
                    idx = (last_v + j) % VOICES;
                    if (g < 0 && pend[VW'(idx)]) g = idx;
                end
                if (g >= 0) begin
                    pend[VW'(g)] = 1'b0;
                    cur_v        = g;
                    start        = cyc + 1;
                    scanning     = 1'b1;
                end else begin
                    scanning = 1'b0;
                end
            end
            if (vr) pend[VW'(vn)] = 1'b1;
            if (ar) pend = '1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic clear_obs();
        obs_wr    = 0;
        obs_done  = 0;
        obs_done3 = 0;
        first_wr  = -1;
        done_at   = -1;
        done_q.delete();
    endtask

    initial begin
        int t;
        bit hit;
        int exp5[$];
        rst           = 1'b1;
        bus.voice_req = 1'b0;
        bus.voice_num = '0;
        bus.all_req   = 1'b0;
        bus.pitch_in  = '0;

        // Reset, then fill the table with no requests.
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        clear_obs();
        idle(140);
        check("t1_writes", 32'(obs_wr), 32'(32));
        check("t1_dones", 32'(obs_done), 32'(8));
        for (int i = 0; i < 8; i++)
            if (i < done_q.size()) check("t1_order", 32'(done_q[i]), 32'(i));

        // Single voice from idle: latency to first write and to completion.
        idle(3);
        clear_obs();
        t = cyc;
        step(1'b0, 1'b1, 5, 1'b0);
        idle(22);
        check("t2_first_wr_lat", 32'(first_wr - t), 32'(6));
        check("t2_done_lat", 32'(done_at - t), 32'(18));

        // Two requests arriving during voice 2's scan are served round-robin after it.
        clear_obs();
        step(1'b0, 1'b1, 2, 1'b0);
        idle(6);
        step(1'b0, 1'b1, 6, 1'b0);
        step(1'b0, 1'b1, 1, 1'b0);
        idle(60);
        check("t3_count", 32'(done_q.size()), 32'(3));
        if (done_q.size() == 3) begin
            check("t3_first", 32'(done_q[0]), 32'(2));
            check("t3_second", 32'(done_q[1]), 32'(6));
            check("t3_third", 32'(done_q[2]), 32'(1));
        end

        // Re-request of the voice being scanned triggers a second full scan.
        clear_obs();
        step(1'b0, 1'b1, 3, 1'b0);
        idle(8);
        step(1'b0, 1'b1, 3, 1'b0);
        idle(45);
        check("t4_done3", 32'(obs_done3), 32'(2));

        // all_req mid-scan of voice 4.
        clear_obs();
        step(1'b0, 1'b1, 4, 1'b0);
        idle(6);
        step(1'b0, 1'b0, 0, 1'b1);
        idle(8 * SCAN_LEN + 30);
        exp5 = '{4, 5, 6, 7, 0, 1, 2, 3, 4};
        check("t5_count", 32'(done_q.size()), 32'(exp5.size()));
        foreach (exp5[i])
            if (i < done_q.size()) check("t5_order", 32'(done_q[i]), 32'(exp5[i]));

        // Reset landing on cnt==2 of a later slot.
        step(1'b0, 1'b0, 0, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (scanning && (cyc - start) > SETTLE && (cyc - start) % SETTLE == 2) begin
                step(1'b1, 1'b0, 0, 1'b0);
                hit = 1'b1;
            end else begin
                step(1'b0, 1'b0, 0, 1'b0);
            end
        end
        check("t6_reset_hit", 32'(hit), 32'(1));
        clear_obs();
        idle(20);
        check("t6_restart_v0", 32'(done_at >= 0 ? done_q[0] : 99), 32'(0));

        // Random traffic with occasional resets.
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 599) == 0, $urandom_range(0, 14) == 0,
                 int'($urandom_range(0, VOICES - 1)), $urandom_range(0, 299) == 0);
        idle(200);
        check("final_idle", 32'(bus.busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
